// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// One-position combinational shift of a word, built from per-bit mux cells.
// With en low the word passes through untouched and nothing is shifted out.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic             dir,
    input  logic             fill,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] next_word,
    output logic             shift_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_hi;
        logic from_lo;

        // The vacated end of the word takes the fill bit.
        if (i == WIDTH - 1) begin : g_msb
            assign from_hi = fill;
        end else begin : g_upper
            assign from_hi = word[i+1];
        end

        if (i == 0) begin : g_lsb
            assign from_lo = fill;
        end else begin : g_lower
            assign from_lo = word[i-1];
        end

        assign next_word[i] = !en ? word[i] : ((dir == DIR_RIGHT) ? from_hi : from_lo);
    end

    assign shift_out = en & ((dir == DIR_LEFT) ? word[WIDTH-1] : word[0]);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: loads a word, shifts it one position per clock for a
// programmed number of steps, then pulses done with the result and last carry.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   data_q;
    logic               carry_q;
    logic [AMT_W-1:0]   count_q;
    logic               dir_q;
    logic               fill_q;
    logic [WIDTH-1:0]   stage_word;
    logic               stage_out;
    logic               accept;

    // A start arriving mid-shift is dropped; DONE may chain straight into a new op.
    assign accept = start_i && (state_q != SHIFT);

    shift_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .en       (state_q == SHIFT),
        .dir      (dir_q),
        .fill     (fill_q),
        .word     (data_q),
        .next_word(stage_word),
        .shift_out(stage_out)
    );

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = (amount_i != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            dir_q   <= DIR_RIGHT;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q  <= data_i;
                carry_q <= 1'b0;
                count_q <= amount_i;
                dir_q   <= dir_i;
                fill_q  <= fill_i;
            end else if (state_q == SHIFT) begin
                data_q  <= stage_word;
                carry_q <= stage_out;
                count_q <= count_q - AMT_W'(1);
            end
        end
    end

    assign data_o  = data_q;
    assign carry_o = carry_q;
    assign busy_o  = (state_q == SHIFT);
    assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a window-sliding reference model predicts
// every intermediate and final word; a monitor checks each done pulse against a queue.
module tb_shift_sequencer;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        int           done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          dir;
    logic [AW-1:0] amount;
    logic          fill;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          carry;
    logic          busy;
    logic          done;

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    exp_t sb_q[$];

    shift_sequencer #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .dir_i   (dir),
        .amount_i(amount),
        .fill_i  (fill),
        .data_i  (data_in),
        .data_o  (data_out),
        .carry_o (carry),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word after n shifts seen as a W-bit window sliding over the operand padded
    // with fill bits on the side that fills in; carry is the bit just past the window.
    function automatic logic [W:0] ref_shift(input logic [W-1:0] d, input logic dl,
                                             input int n, input logic f);
        logic [3*W-1:0] ext;
        if (n == 0) return {1'b0, d};
        if (dl == 1'b0) begin
            ext = {{(2*W){f}}, d};
            return {ext[n-1], ext[n +: W]};
        end
        ext = {d, {(2*W){f}}};
        return {ext[3*W-n], ext[2*W-n +: W]};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_data", 32'(data_out), 32'(e.data));
                check("sb_carry", 32'(carry), 32'(e.carry));
                check("sb_done_cycle", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    // Called just after a falling edge; the start is accepted on the next rising edge.
    task automatic issue(input logic [W-1:0] d, input logic dl, input int n, input logic f);
        exp_t       e;
        logic [W:0] r;
        r          = ref_shift(d, dl, n, f);
        e.data     = r[W-1:0];
        e.carry    = r[W];
        e.done_cyc = cyc + n + 1;
        sb_q.push_back(e);
        data_in = d;
        dir     = dl;
        amount  = AW'(n);
        fill    = f;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walks every cycle of an operation, checking the working word, busy and done.
    // Returns on the falling edge inside the DONE cycle.  Optionally raises a
    // competing start during SHIFT, which must be ignored.
    task automatic follow(input logic [W-1:0] d, input logic dl, input int n,
                          input logic f, input bit inject);
        logic [W:0] r;
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            if (inject && i == 1) begin
                start   = 1'b1;
                data_in = '1;
                dir     = ~dl;
                amount  = AW'(1);
            end
            if (inject && i == 2) start = 1'b0;
            r = ref_shift(d, dl, i - 1, f);
            check("step_data", 32'(data_out), 32'(r[W-1:0]));
            check("step_carry", 32'(carry), 32'(r[W]));
            check("step_busy", 32'(busy), 32'(i - 1 < n));
            check("step_done", 32'(done), 32'(i == n + 1));
        end
    endtask

    task automatic op(input logic [W-1:0] d, input logic dl, input int n, input logic f);
        issue(d, dl, n, f);
        follow(d, dl, n, f, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        amount  = '0;
        fill    = 1'b0;
        data_in = '0;

        repeat (2) @(negedge clk);
        check("reset_data", 32'(data_out), 32'(0));
        check("reset_carry", 32'(carry), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        op(8'hB5, 1'b0, 3, 1'b0);
        check("right_b5_result", 32'(data_out), 32'h16);
        @(negedge clk);
        op(8'h81, 1'b1, 2, 1'b1);
        check("left_81_result", 32'(data_out), 32'h07);
        @(negedge clk);
        op(8'h5A, 1'b0, 0, 1'b1);
        check("zero_amt_result", 32'(data_out), 32'h5A);
        @(negedge clk);
        op(8'h00, 1'b0, 8, 1'b1);
        check("saturate_result", 32'(data_out), 32'hFF);
        check("saturate_carry", 32'(carry), 32'(0));

        // Start while busy is ignored, then a start in DONE chains immediately.
        @(negedge clk);
        issue(8'h3C, 1'b1, 5, 1'b0);
        follow(8'h3C, 1'b1, 5, 1'b0, 1'b1);
        op(8'hA7, 1'b0, 4, 1'b1);
        op(8'h69, 1'b1, 11, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] d;
            logic         dl;
            logic         f;
            int           n;
            d  = W'($urandom);
            dl = 1'($urandom);
            f  = 1'($urandom);
            n  = int'($urandom_range(0, (1 << AW) - 1));
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            op(d, dl, n, f);
        end

        // Asynchronous reset between edges mid-shift discards the operation.
        @(negedge clk);
        issue(8'hC3, 1'b0, 10, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_data", 32'(data_out), 32'(0));
        check("midreset_carry", 32'(carry), 32'(0));
        check("midreset_busy", 32'(busy), 32'(0));
        check("midreset_done", 32'(done), 32'(0));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'(0));
        check("post_reset_data", 32'(data_out), 32'(0));

        @(negedge clk);
        op(8'h96, 1'b1, 1, 1'b1);
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
